bullet_ctrl: RTL and testbench

Per-player projectile controller, one instance per tank. Owns a bullet's position and lifetime. It spawns the bullet at the tank muzzle on a fire press and steps it once per frame. It retires the bullet on a barrier collision, tank hit, screen edge or lifetime expiry. BulletX/BulletY feed the barrier collision checker; that checker's bullet_N_collision output returns as barrier_hit.

---
 rtl/bullet_ctrl_if.sv | 24 ++
 rtl/bullet_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bullet_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_ctrl_if.sv
// Bus between a tank's control logic and its projectile controller.
// The master side supplies tank pose, fire and collision feedback; the slave returns bullet state.
interface bullet_ctrl_if;
  logic       fire;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [1:0] Dir;
  logic       barrier_hit;
  logic       tank_hit;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic       bullet_active;
  logic       hit_pulse;

  modport master (
    output fire, TankX, TankY, Dir, barrier_hit, tank_hit,
    input  BulletX, BulletY, bullet_active, hit_pulse
  );

  modport slave (
    input  fire, TankX, TankY, Dir, barrier_hit, tank_hit,
    output BulletX, BulletY, bullet_active, hit_pulse
  );
endinterface

// File: rtl/bullet_ctrl.sv
// Per-tank projectile controller: spawns a bullet at the muzzle on a fire press, steps it once
// per frame, and retires it on tank hit, barrier hit, screen edge or lifetime expiry.
module bullet_ctrl #(
  parameter int SPEED     = 4,
  parameter int SPAWN_OFS = 8,
  parameter int LIFETIME  = 120,
  parameter int COOLDOWN  = 30,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int PARK_X    = 1000,
  parameter int PARK_Y    = 1000
) (
  input logic          frame_clk,
  input logic          Reset,
  bullet_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDN} state_t;
  typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11} dir_t;

  localparam logic [10:0] OFS11   = 11'(SPAWN_OFS);
  localparam logic [10:0] SPD11   = 11'(SPEED);
  localparam logic [10:0] XMAX11  = 11'(X_MAX);
  localparam logic [10:0] YMAX11  = 11'(Y_MAX);
  localparam logic [9:0]  PARK_X10 = 10'(PARK_X);
  localparam logic [9:0]  PARK_Y10 = 10'(PARK_Y);
  localparam logic [7:0]  LIFE_LAST = 8'(LIFETIME - 1);
  localparam logic [7:0]  CD_LAST   = 8'(COOLDOWN - 1);

  state_t     state, state_d;
  dir_t       dir_q, dir_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       active_q, active_d;
  logic       pulse_q, pulse_d;
  logic       fire_prev;
  logic [7:0] life_cnt, life_d;
  logic [7:0] cd_cnt, cd_d;

  logic        fire_edge;
  logic [10:0] tank_x11, tank_y11, spawn_x, spawn_y;
  logic        spawn_ok;
  logic [10:0] cur_x11, cur_y11, step_x, step_y;
  logic        off_screen;

  assign fire_edge = bus.fire & ~fire_prev;
  assign tank_x11  = {1'b0, bus.TankX};
  assign tank_y11  = {1'b0, bus.TankY};
  assign cur_x11   = {1'b0, x_q};
  assign cur_y11   = {1'b0, y_q};

  // Underflow wraps to >= 2040 in 11 bits, so the upper-bound test also rejects it.
  always_comb begin
    spawn_x = tank_x11;
    spawn_y = tank_y11;
    case (dir_t'(bus.Dir))
      DIR_UP:    spawn_y = tank_y11 - OFS11;
      DIR_DOWN:  spawn_y = tank_y11 + OFS11;
      DIR_LEFT:  spawn_x = tank_x11 - OFS11;
      DIR_RIGHT: spawn_x = tank_x11 + OFS11;
      default:   spawn_x = tank_x11;
    endcase
    spawn_ok = (spawn_x <= XMAX11) && (spawn_y <= YMAX11);
  end

  always_comb begin
    step_x     = cur_x11;
    step_y     = cur_y11;
    off_screen = 1'b0;
    case (dir_q)
      DIR_UP: begin
        off_screen = cur_y11 < SPD11;
        step_y     = cur_y11 - SPD11;
      end
      DIR_DOWN: begin
        off_screen = (cur_y11 + SPD11) > YMAX11;
        step_y     = cur_y11 + SPD11;
      end
      DIR_LEFT: begin
        off_screen = cur_x11 < SPD11;
        step_x     = cur_x11 - SPD11;
      end
      DIR_RIGHT: begin
        off_screen = (cur_x11 + SPD11) > XMAX11;
        step_x     = cur_x11 + SPD11;
      end
      default: off_screen = 1'b1;
    endcase
  end

  // NOTE: every signal written here gets its default first so no path can infer a latch.
  always_comb begin
    state_d  = state;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    pulse_d  = 1'b0;
    life_d   = life_cnt;
    cd_d     = cd_cnt;
    case (state)
      IDLE: begin
        if (fire_edge && spawn_ok) begin
          state_d  = FLYING;
          dir_d    = dir_t'(bus.Dir);
          x_d      = spawn_x[9:0];
          y_d      = spawn_y[9:0];
          life_d   = 8'd0;
          active_d = 1'b1;
        end
      end
      FLYING: begin
        if (bus.tank_hit || bus.barrier_hit || off_screen || life_cnt == LIFE_LAST) begin
          state_d  = COOLDN;
          cd_d     = 8'd0;
          active_d = 1'b0;
          x_d      = PARK_X10;
          y_d      = PARK_Y10;
          pulse_d  = bus.tank_hit;
        end else begin
          x_d    = step_x[9:0];
          y_d    = step_y[9:0];
          life_d = life_cnt + 8'd1;
        end
      end
      COOLDN: begin
        if (cd_cnt == CD_LAST) state_d = IDLE;
        else                   cd_d    = cd_cnt + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      dir_q     <= DIR_UP;
      x_q       <= PARK_X10;
      y_q       <= PARK_Y10;
      active_q  <= 1'b0;
      pulse_q   <= 1'b0;
      fire_prev <= 1'b0;
      life_cnt  <= 8'd0;
      cd_cnt    <= 8'd0;
    end else begin
      state     <= state_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      active_q  <= active_d;
      pulse_q   <= pulse_d;
      fire_prev <= bus.fire;
      life_cnt  <= life_d;
      cd_cnt    <= cd_d;
    end
  end

  assign bus.BulletX       = x_q;
  assign bus.BulletY       = y_q;
  assign bus.bullet_active = active_q;
  assign bus.hit_pulse     = pulse_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: a trajectory-level model (spawn point + age * speed) checked every frame,
// plus literal expectations at key points of the directed scenarios.
module tb_bullet_ctrl;
  localparam int SPEED     = 4;
  localparam int SPAWN_OFS = 8;
  localparam int LIFETIME  = 120;
  localparam int COOLDOWN  = 30;
  localparam int X_MAX     = 639;
  localparam int Y_MAX     = 479;
  localparam int PARK      = 1000;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  bullet_ctrl_if bus();

  bullet_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bullet is a spawn point plus age steps along its heading; cooldown is frames remaining.
  bit m_act, m_pulse, m_prev, m_fe;
  int m_dir, m_age, m_cool, m_sx, m_sy, m_nx, m_ny, c_sx, c_sy;

  function automatic int dx_of(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int dy_of(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  function automatic int exp_x();
    return m_act ? m_sx + dx_of(m_dir) * SPEED * m_age : PARK;
  endfunction

  function automatic int exp_y();
    return m_act ? m_sy + dy_of(m_dir) * SPEED * m_age : PARK;
  endfunction

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_act = 0; m_pulse = 0; m_prev = 0; m_cool = 0; m_age = 0; m_dir = 0;
    end else begin
      m_fe    = bus.fire && !m_prev;
      m_pulse = 0;
      if (m_act) begin
        m_nx = exp_x() + dx_of(m_dir) * SPEED;
        m_ny = exp_y() + dy_of(m_dir) * SPEED;
        if (bus.tank_hit) begin
          m_act = 0; m_pulse = 1; m_cool = COOLDOWN;
        end else if (bus.barrier_hit || m_nx < 0 || m_nx > X_MAX || m_ny < 0 || m_ny > Y_MAX
                     || m_age == LIFETIME - 1) begin
          m_act = 0; m_cool = COOLDOWN;
        end else begin
          m_age++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_fe) begin
        c_sx = int'(bus.TankX) + dx_of(int'(bus.Dir)) * SPAWN_OFS;
        c_sy = int'(bus.TankY) + dy_of(int'(bus.Dir)) * SPAWN_OFS;
        if (c_sx >= 0 && c_sx <= X_MAX && c_sy >= 0 && c_sy <= Y_MAX) begin
          m_act = 1; m_age = 0; m_dir = int'(bus.Dir); m_sx = c_sx; m_sy = c_sy;
        end
      end
      m_prev = bus.fire;
    end
  end

  always @(negedge frame_clk) begin
    if (cmp_en) begin
      check("model_x",      bus.BulletX,       exp_x());
      check("model_y",      bus.BulletY,       exp_y());
      check("model_active", bus.bullet_active, m_act);
      check("model_pulse",  bus.hit_pulse,     m_pulse);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  int  act_frames, bullets;
  bit  was_act;

  initial begin
    bus.fire = 0; bus.TankX = 10'd100; bus.TankY = 10'd200; bus.Dir = 2'b11;
    bus.barrier_hit = 0; bus.tank_hit = 0;

    // Reset state
    #12;
    check("rst_x", bus.BulletX, 1000);
    check("rst_y", bus.BulletY, 1000);
    check("rst_active", bus.bullet_active, 0);
    check("rst_pulse", bus.hit_pulse, 0);
    step(1);
    Reset = 0;
    cmp_en = 1;
    step(2);

    // Spawn right, fly, then show heading is frozen
    bus.fire = 1;
    step(1);
    check("spawn_x", bus.BulletX, 108);
    check("spawn_y", bus.BulletY, 200);
    check("spawn_active", bus.bullet_active, 1);
    step(3);
    check("fly3_x", bus.BulletX, 120);
    bus.Dir = 2'b00;
    step(2);
    check("frozen_x", bus.BulletX, 128);
    check("frozen_y", bus.BulletY, 200);

    // Barrier retire, fire during cooldown ignored, fire after cooldown spawns
    bus.barrier_hit = 1;
    step(1);
    bus.barrier_hit = 0;
    check("barrier_active", bus.bullet_active, 0);
    check("barrier_x", bus.BulletX, 1000);
    bus.fire = 0;
    step(9);
    bus.fire = 1;
    step(1);
    check("cd_ignore_active", bus.bullet_active, 0);
    bus.fire = 0;
    step(30);
    bus.fire = 1;
    step(1);
    check("after_cd_active", bus.bullet_active, 1);
    check("after_cd_y", bus.BulletY, 192);

    // tank_hit together with barrier_hit
    bus.tank_hit = 1; bus.barrier_hit = 1;
    step(1);
    bus.tank_hit = 0; bus.barrier_hit = 0;
    check("hit_pulse_on", bus.hit_pulse, 1);
    check("hit_active", bus.bullet_active, 0);
    step(1);
    check("hit_pulse_off", bus.hit_pulse, 0);
    bus.fire = 0;
    step(32);

    // Left spawn near the edge retires without wrapping
    bus.TankX = 10'd10; bus.TankY = 10'd50; bus.Dir = 2'b10;
    bus.fire = 1;
    step(1);
    check("left_spawn_x", bus.BulletX, 2);
    check("left_spawn_active", bus.bullet_active, 1);
    step(1);
    check("edge_retire_active", bus.bullet_active, 0);
    check("edge_retire_x", bus.BulletX, 1000);
    bus.fire = 0;
    step(32);

    // Illegal spawn stays idle
    bus.TankX = 10'd4;
    bus.fire = 1;
    step(1);
    check("illegal_active", bus.bullet_active, 0);
    bus.fire = 0;
    step(1);

    // tank_hit in IDLE is ignored
    bus.tank_hit = 1;
    step(2);
    check("idle_tank_hit_pulse", bus.hit_pulse, 0);
    bus.tank_hit = 0;
    step(1);

    // Fire held for 500 frames: one bullet, full lifetime
    bus.TankX = 10'd20; bus.TankY = 10'd240; bus.Dir = 2'b11;
    bus.fire = 1;
    act_frames = 0; bullets = 0; was_act = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (bus.bullet_active) act_frames++;
      if (bus.bullet_active && !was_act) bullets++;
      was_act = bus.bullet_active;
    end
    check("held_active_frames", act_frames, LIFETIME);
    check("held_bullets", bullets, 1);
    bus.fire = 0;
    step(1);
    bus.fire = 1;
    step(1);
    check("repress_x", bus.BulletX, 28);
    step(3);
    check("repress_fly_x", bus.BulletX, 40);

    // Asynchronous reset mid-flight
    #3 Reset = 1;
    #1;
    check("async_rst_x", bus.BulletX, 1000);
    check("async_rst_y", bus.BulletY, 1000);
    check("async_rst_active", bus.bullet_active, 0);
    check("async_rst_pulse", bus.hit_pulse, 0);
    bus.fire = 0;
    step(2);
    Reset = 0;
    step(1);
    bus.fire = 1;
    step(1);
    check("post_rst_spawn_x", bus.BulletX, 28);
    check("post_rst_active", bus.bullet_active, 1);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
